// File: rtl/nn_seq_ctrl.sv
// Sequencer for the two-layer neuron datapath: steps S hidden neurons, drives accumulator, presents Y.
// Latency S+2 from input handshake to out_valid; Y is held in DONE until out_ready, no new input meanwhile.
module nn_seq_ctrl #(
  parameter int S    = 8,
  parameter int AW   = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            in_load,
  input  logic            abort,
  output logic [AW-1:0]   addr_r,
  output logic [AW-1:0]   addr_c,
  output logic            acc_clr,
  output logic            acc_en,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            finished,
  output logic [CNTW-1:0] frame_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [AW-1:0] LAST = AW'(S - 1);

  logic [1:0]    state;
  logic [AW-1:0] idx;

  assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign in_load  = in_valid & in_ready;
  assign finished = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      addr_r    <= '0;
      addr_c    <= '0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      acc_clr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_load) begin
            state   <= ST_RUN;
            idx     <= '0;
            addr_r  <= '0;
            addr_c  <= '0;
            acc_en  <= 1'b0;
            acc_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state  <= ST_IDLE;
            idx    <= '0;
            addr_r <= '0;
            addr_c <= '0;
            acc_en <= 1'b0;
            busy   <= 1'b0;
          end else begin
            // addr_c trails addr_r by one cycle to line up with the registered hidden value
            acc_en <= 1'b1;
            addr_c <= idx;
            if (idx == LAST) begin
              state <= ST_DRAIN;
            end else begin
              idx    <= idx + AW'(1);
              addr_r <= idx + AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          state  <= abort ? ST_IDLE : ST_DONE;
          idx    <= '0;
          addr_r <= '0;
          addr_c <= '0;
          acc_en <= 1'b0;
          busy   <= 1'b0;
          if (!abort) begin
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            frame_cnt <= frame_cnt + CNTW'(1);
            out_valid <= 1'b0;
            if (in_load) begin
              state   <= ST_RUN;
              idx     <= '0;
              addr_r  <= '0;
              addr_c  <= '0;
              acc_en  <= 1'b0;
              acc_clr <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// Randomized bench for nn_seq_ctrl: an S=8 and an S=1 instance run side by side against a frame-position model.
module tb_nn_seq_ctrl;

  localparam int AW   = 4;
  localparam int CNTW = 8;
  localparam int NCYC = 8000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset     [2];
  logic            in_valid  [2];
  logic            in_ready  [2];
  logic            in_load   [2];
  logic            abort     [2];
  logic [AW-1:0]   addr_r    [2];
  logic [AW-1:0]   addr_c    [2];
  logic            acc_clr   [2];
  logic            acc_en    [2];
  logic            busy      [2];
  logic            out_valid [2];
  logic            out_ready [2];
  logic            finished  [2];
  logic [CNTW-1:0] frame_cnt [2];

  int checks = 0;
  int errors = 0;

  // Model: pos = cycles since the frame was accepted (0 = no frame running), done = Y waiting.
  int sz    [2] = '{8, 1};
  int m_pos [2];
  bit m_done[2];
  int m_cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    nn_seq_ctrl #(.S(g == 0 ? 8 : 1), .AW(AW), .CNTW(CNTW)) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_load   (in_load[g]),
      .abort     (abort[g]),
      .addr_r    (addr_r[g]),
      .addr_c    (addr_c[g]),
      .acc_clr   (acc_clr[g]),
      .acc_en    (acc_en[g]),
      .busy      (busy[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .finished  (finished[g]),
      .frame_cnt (frame_cnt[g])
    );
  end

  task automatic chk(input string tag, input int inst, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[S=%0d] at %0t: got %0d expected %0d", tag, sz[inst], $time, got, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_pos[i]  = 0;
    m_done[i] = 1'b0;
    m_cnt[i]  = 0;
  endtask

  function automatic bit model_rdy(input int i);
    return (m_pos[i] == 0 && !m_done[i]) || (m_done[i] && out_ready[i]);
  endfunction

  task automatic check_outputs(input int i);
    int p, s, e_ar, e_ac;
    bit e_en, e_rdy;
    p = m_pos[i];
    s = sz[i];
    e_ar  = (p >= 1 && p <= s) ? p - 1 : (p == s + 1 ? s - 1 : 0);
    e_en  = (p >= 2);
    e_ac  = e_en ? p - 2 : 0;
    e_rdy = model_rdy(i);
    chk("addr_r",    i, int'(addr_r[i]),    e_ar);
    chk("addr_c",    i, int'(addr_c[i]),    e_ac);
    chk("acc_en",    i, int'(acc_en[i]),    int'(e_en));
    chk("acc_clr",   i, int'(acc_clr[i]),   int'(p == 1));
    chk("busy",      i, int'(busy[i]),      int'(p > 0));
    chk("out_valid", i, int'(out_valid[i]), int'(m_done[i]));
    chk("frame_cnt", i, int'(frame_cnt[i]), m_cnt[i]);
    chk("in_ready",  i, int'(in_ready[i]),  int'(e_rdy));
    chk("in_load",   i, int'(in_load[i]),   int'(e_rdy && in_valid[i]));
    chk("finished",  i, int'(finished[i]),  int'(m_done[i] && out_ready[i]));
  endtask

  task automatic model_step(input int i);
    bit acc;
    if (!reset[i]) begin
      model_reset(i);
      return;
    end
    acc = in_valid[i] && model_rdy(i);
    if (m_done[i]) begin
      if (out_ready[i]) begin
        m_cnt[i]  = (m_cnt[i] + 1) % (1 << CNTW);
        m_done[i] = 1'b0;
        m_pos[i]  = acc ? 1 : 0;
      end
    end else if (m_pos[i] == 0) begin
      if (acc) m_pos[i] = 1;
    end else if (abort[i]) begin
      m_pos[i] = 0;
    end else if (m_pos[i] == sz[i] + 1) begin
      m_pos[i]  = 0;
      m_done[i] = 1'b1;
    end else begin
      m_pos[i]++;
    end
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic drive(input int i, input int cyc);
    int pv, pr, pa, pz;
    if (cyc < 40) begin
      pv = 0; pr = 100; pa = 0; pz = 0;
    end else if (cyc < 200) begin
      pv = 50; pr = 20; pa = 0; pz = 0;
    end else if (cyc < 400) begin
      pv = 100; pr = 100; pa = 0; pz = 0;
    end else if (cyc < 5000) begin
      pv = 70; pr = 70; pa = 4; pz = 1;
    end else begin
      pv = 100; pr = 100; pa = 0; pz = 0;
    end
    in_valid[i]  = (cyc < 40) ? (cyc == 2) : roll(pv);
    out_ready[i] = roll(pr);
    abort[i]     = roll(pa);
    // a reset pulse lasts one cycle, then is released
    if (!reset[i]) reset[i] = 1'b1;
    else if (roll(pz)) reset[i] = 1'b0;
    if (!reset[i]) model_reset(i);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset[i]     = 1'b0;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      abort[i]     = 1'b0;
      model_reset(i);
    end
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) reset[i] = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) drive(i, cyc);
      #1;
      for (int i = 0; i < 2; i++) check_outputs(i);
      // handshake at cycle 2: out_valid first high at 2+S+2
      if (cyc == 11) chk("lat_pre",  0, int'(out_valid[0]), 0);
      if (cyc == 12) chk("lat_s8",   0, int'(out_valid[0]), 1);
      if (cyc == 4)  chk("lat_pre",  1, int'(out_valid[1]), 0);
      if (cyc == 5)  chk("lat_s1",   1, int'(out_valid[1]), 1);
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
